// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and state encoding for multdiv_sequencer (DIV state only with MULTDIV_DIV_EN)
package multdiv_pkg;
   localparam int WIDTH = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W = 6;
`ifdef MULTDIV_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd3} state_t;
`endif
endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: 33-bit adder/subtractor shared by the Booth and restoring-divide steps
module multdiv_addsub import multdiv_pkg::*; (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] sum
);
   assign sum = sub ? a - b : a + b;
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: 32-iteration Booth multiplier / restoring divider; divide only with MULTDIV_DIV_EN
module multdiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   import multdiv_pkg::*;
   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [2*WIDTH:0]     acc, acc_n;
   logic [WIDTH-1:0]     opb, opb_n, res_n;
   logic                 exc_n, err, err_n;
   logic [WIDTH:0]       add_a, add_b, add_s;
   logic                 add_sub;
   wire                  start = ctrl_MULT | ctrl_DIV;
   wire                  last = cnt == CNT_W'(ITER_COUNT);
`ifdef MULTDIV_DIV_EN
   logic                 neg, neg_n, dovf, dovf_n;
   wire  [WIDTH-1:0]     mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   wire  [WIDTH-1:0]     mag_b = opb[WIDTH-1] ? -opb : opb;
   wire  [WIDTH:0]       rem2 = acc[2*WIDTH-1:WIDTH-1];
`endif
   multdiv_addsub u_addsub (.a(add_a), .b(add_b), .sub(add_sub), .sum(add_s));
   assign data_resultRDY = state == DONE;
   // state, iteration counter, datapath and result registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         opb <= '0;
         err <= 1'b0;
         data_result <= '0;
         data_exception <= 1'b0;
`ifdef MULTDIV_DIV_EN
         neg <= 1'b0;
         dovf <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         acc <= acc_n;
         opb <= opb_n;
         err <= err_n;
         data_result <= res_n;
         data_exception <= exc_n;
`ifdef MULTDIV_DIV_EN
         neg <= neg_n;
         dovf <= dovf_n;
`endif
      end
   end
   // next state: start pulses restart from any state, otherwise one Booth or divide step per edge
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      acc_n = acc;
      opb_n = opb;
      err_n = 1'b0;
      res_n = data_result;
      exc_n = data_exception;
      add_a = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
      add_b = (acc[1] ^ acc[0]) ? {opb[WIDTH-1], opb} : '0;
      add_sub = acc[1] & ~acc[0];
`ifdef MULTDIV_DIV_EN
      neg_n = neg;
      dovf_n = dovf;
      if (state == DIV) begin
         add_a = rem2;
         add_b = {1'b0, mag_b};
         add_sub = 1'b1;
      end
`endif
      if (start) begin
         cnt_n = '0;
         opb_n = data_operandB;
         if (ctrl_MULT) begin
            state_n = MULT;
            acc_n = {WIDTH'(0), data_operandA, 1'b0};
         end
`ifdef MULTDIV_DIV_EN
         else if (data_operandB != '0) begin
            state_n = DIV;
            acc_n = {(WIDTH+1)'(0), mag_a};
            neg_n = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dovf_n = data_operandA == {1'b1, (WIDTH-1)'(0)} && &data_operandB;
         end
`endif
         else begin
            state_n = IDLE;
            err_n = 1'b1;
         end
      end else if (state == MULT) begin
         state_n = last ? DONE : MULT;
         cnt_n = last ? cnt : cnt + CNT_W'(1);
         acc_n = last ? acc : {add_s, acc[WIDTH:1]};
         res_n = last ? acc[WIDTH:1] : data_result;
         exc_n = last ? ~(&acc[2*WIDTH:WIDTH] | ~|acc[2*WIDTH:WIDTH]) : data_exception;
      end
`ifdef MULTDIV_DIV_EN
      else if (state == DIV) begin
         state_n = last ? DONE : DIV;
         cnt_n = last ? cnt : cnt + CNT_W'(1);
         acc_n = last ? acc : {add_s[WIDTH] ? rem2 : add_s, acc[WIDTH-2:0], ~add_s[WIDTH]};
         res_n = last ? (neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : data_result;
         exc_n = last ? dovf : data_exception;
      end
`endif
      else if (state == DONE) begin
         state_n = IDLE;
      end else if (err) begin
         state_n = DONE;
         res_n = '0;
         exc_n = 1'b1;
      end
   end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: randomized self-checking bench against an arithmetic reference model (honours MULTDIV_DIV_EN)
module tb_multdiv_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   int          n_checks = 0;
   int          n_errors = 0;

   multdiv_sequencer #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: the arithmetic answer and the number of edges from the start edge to RDY
   task automatic model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc);
      logic signed [63:0] sa, sb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (mult) begin
         p = sa * sb;
         res = p[31:0];
         exc = !(p[63:31] == '0 || p[63:31] == '1);
         lat = 33;
      end else begin
`ifdef MULTDIV_DIV_EN
         if (b == 0) begin
            res = 0; exc = 1; lat = 1;
         end else begin
            p = sa / sb;
            res = p[31:0];
            exc = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
            lat = 33;
         end
`else
         res = 0; exc = 1; lat = 1;
`endif
      end
   endtask

   task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
      @(posedge clock);
      #1;
      ctrl_MULT = 0; ctrl_DIV = 0;
      data_operandA = $urandom; data_operandB = $urandom;
   endtask

   task automatic wait_done(input string tag, input int lat, input logic [31:0] res, input logic exc);
      int n = 0;
      while (n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (data_resultRDY) break;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " result"}, 64'(data_result), 64'(res));
      check({tag, " exception"}, 64'(data_exception), 64'(exc));
      @(posedge clock);
      #1;
      check({tag, " rdy drop"}, 64'(data_resultRDY), 64'd0);
      check({tag, " hold"}, 64'(data_result), 64'(res));
   endtask

   task automatic run(input string tag, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      int lat; logic [31:0] res; logic exc;
      model(m, a, b, lat, res, exc);
      start_op(m, d, a, b);
      wait_done(tag, lat, res, exc);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] sp [5] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h7FFFFFFF};
      return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : 32'($urandom);
   endfunction

   initial begin
      int rdy_seen;
      int lat; logic [31:0] res; logic exc;
      #12;
      check("reset result", 64'(data_result), 64'd0);
      check("reset exception", 64'(data_exception), 64'd0);
      check("reset rdy", 64'(data_resultRDY), 64'd0);
      @(negedge clock);
      reset = 0;
      rdy_seen = 0;
      repeat (5) begin @(posedge clock); #1; rdy_seen += int'(data_resultRDY); end
      check("idle after reset", 64'(rdy_seen), 64'd0);

      run("mul 7x-3", 1, 0, 32'd7, -32'sd3);
      run("mul overflow", 1, 0, 32'h00010000, 32'h00010000);
      run("mul priority", 1, 1, 32'd6, 32'd9);
      run("div -7/2", 0, 1, -32'sd7, 32'd2);
      run("div 5/0", 0, 1, 32'd5, 32'd0);
      run("div 10/2", 0, 1, 32'd10, 32'd2);
      run("div min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF);
      run("mul min*min", 1, 0, 32'h80000000, 32'h80000000);

      start_op(1, 0, 32'd3, 32'd4);
      rdy_seen = 0;
      repeat (9) begin @(posedge clock); #1; rdy_seen += int'(data_resultRDY); end
      model(0, 32'd100, 32'd7, lat, res, exc);
      start_op(0, 1, 32'd100, 32'd7);
      check("restart no rdy", 64'(rdy_seen + int'(data_resultRDY)), 64'd0);
      wait_done("restart div", lat, res, exc);

      run("mul 5x5", 1, 0, 32'd5, 32'd5);
      start_op(1, 0, 32'd123, 32'd456);
      repeat (14) @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1;
      #1;
      check("async reset result", 64'(data_result), 64'd0);
      check("async reset exception", 64'(data_exception), 64'd0);
      check("async reset rdy", 64'(data_resultRDY), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 0;
      rdy_seen = 0;
      repeat (40) begin @(posedge clock); #1; rdy_seen += int'(data_resultRDY); end
      check("no rdy after reset", 64'(rdy_seen), 64'd0);
      run("mul 2x2", 1, 0, 32'd2, 32'd2);

      for (int i = 0; i < 40; i++) begin
         bit m = 1'($urandom_range(0, 1));
         run(m ? "rand mul" : "rand div", m, !m, pick(), pick());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: data_operandA  in  32  signed multiplicand or dividend.
REQ-005 Port: data_operandB  in  32  signed multiplier or divisor.
REQ-006 Port: ctrl_MULT  in  1  one-cycle start pulse for multiply.
REQ-007 Port: ctrl_DIV  in  1  one-cycle start pulse for divide.
REQ-008 Port: data_result  out  32  low 32 bits of product, or quotient.
REQ-009 Port: data_exception  out  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-010 Port: data_resultRDY  out  1  one-cycle completion pulse.

Function
REQ-011 The block SHALL implement states IDLE, MULT, DIV and DONE.
REQ-012 A start pulse sampled at edge E0 SHALL latch both operands, clear the 6-bit iteration counter and enter MULT or DIV.
REQ-013 Multiply SHALL use radix-2 Booth on a 65-bit {upper, lower, q-1} register, one iteration per edge E1..E32.
REQ-014 Divide SHALL use restoring division on operand magnitudes, one iteration per edge E1..E32, with the quotient negated when the operand signs differ (truncation toward zero).
REQ-015 At E33 the block SHALL enter DONE, register data_result and data_exception, and drive data_resultRDY=1 for exactly that one cycle, returning to IDLE at E34.
REQ-016 Multiply overflow SHALL set data_exception=1 when the upper 33 bits of the 64-bit product are not all equal.
REQ-017 Divide by zero SHALL be detected at E0 and SHALL give data_result=0, data_exception=1, with data_resultRDY at E1.
REQ-018 A divide of 0x80000000 by -1 SHALL give data_result=0x80000000 with data_exception=1.
REQ-019 When ctrl_MULT and ctrl_DIV are asserted in the same cycle, multiply SHALL take priority.
REQ-020 A start pulse in MULT, DIV or DONE SHALL abort the current operation, suppress its data_resultRDY, and restart from E0 with the new operands.
REQ-021 data_result and data_exception SHALL hold their values until the next completion.
REQ-022 Operand inputs SHALL be ignored except at E0.

Reset
REQ-023 On reset, the block SHALL go to IDLE and clear the counter, data_result, data_exception and data_resultRDY, with no pending result and regardless of the current operation.
REQ-024 Deassertion of reset SHALL begin no operation; a fresh start pulse is required.

Configuration
REQ-025 With MULTDIV_DIV_EN defined, divide SHALL behave as in REQ-014 and REQ-017 to REQ-018.
REQ-026 Without MULTDIV_DIV_EN, the DIV state and divide datapath SHALL be absent, and ctrl_DIV SHALL give data_result=0, data_exception=1, data_resultRDY at E1.
REQ-027 Multiply behaviour SHALL be identical with and without MULTDIV_DIV_EN.

Structure
REQ-028 A shared package multdiv_pkg SHALL hold the state encoding, WIDTH, ITER_COUNT=32 and the counter width of 6.
REQ-029 A single 33-bit add/subtract sub-module, multdiv_addsub, SHALL be instantiated once and shared by the Booth step and the restoring-divide step.

Verification
REQ-030 Multiply 7 x -3: ctrl_MULT at E0 -> data_resultRDY only at E33, data_result=0xFFFFFFEB, data_exception=0.
REQ-031 Multiply 0x00010000 x 0x00010000 -> data_result=0x00000000, data_exception=1 at E33.
REQ-032 Divide -7 / 2 -> data_result=0xFFFFFFFD, exception=0 at E33; divide 5 / 0 -> data_result=0, exception=1 at E1.
REQ-033 Restart: ctrl_MULT 3 x 4, then ctrl_DIV 100 / 7 at E10 -> no RDY for the multiply, RDY 33 edges after the restart edge, result=14.
REQ-034 Reset at E15 of a multiply -> all outputs 0 immediately, no RDY afterward; next ctrl_MULT 2 x 2 -> 4 at E33.
REQ-035 Build without MULTDIV_DIV_EN: ctrl_DIV 10 / 2 -> result=0, exception=1, RDY at E1; multiply still correct.
